// File: rtl/ics32_flash_reader.sv
// SPI flash READ master: issues one read command for a start address, then streams
// little-endian DATA_WIDTH words over valid/ready. Optional FLASH_READER_FAST_READ_EN selects 0x0B + 8 dummy bits.
module ics32_flash_reader #(
  parameter int DATA_WIDTH      = 16,
  parameter int CSN_IDLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_start,
  input  logic [23:0]           read_address,
  input  logic [15:0]           read_length,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  flash_sck,
  output logic                  flash_csn,
  output logic                  flash_mosi,
  input  logic                  flash_miso
);

  localparam int PW = $clog2(DATA_WIDTH);
  localparam int IW = $clog2(CSN_IDLE_CYCLES + 1);
`ifdef FLASH_READER_FAST_READ_EN
  localparam logic [7:0] READ_CMD = 8'h0B;
`else
  localparam logic [7:0] READ_CMD = 8'h03;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_END   = 3'd5
  } state_t;

  state_t                state_r, state_s, hdr_next_s;
  logic [4:0]            bit_cnt_r, bit_cnt_s, hdr_last_s;
  logic [39:0]           tx_r, tx_s;
  logic [15:0]           word_cnt_r, word_cnt_s;
  logic [DATA_WIDTH-1:0] rx_r, rx_s, data_r, data_s;
  logic [IW-1:0]         idle_cnt_r, idle_cnt_s;
  logic                  data_valid_r, data_valid_s;
  logic                  busy_r, busy_s;
  logic                  sck_r, sck_s;
  logic                  csn_r, csn_s;
  logic                  mosi_r, mosi_s;
  logic [PW-1:0]         pos_s;

  // Bits arrive MSB-first within a byte, bytes fill the word from the low end.
  assign pos_s = PW'({bit_cnt_r[4:3], ~bit_cnt_r[2:0]});

  // Length and successor of the current command/address/dummy field.
  always_comb begin
    hdr_last_s = 5'd7;
    hdr_next_s = ST_ADDR;
    case (state_r)
      ST_CMD: begin
        hdr_last_s = 5'd7;
        hdr_next_s = ST_ADDR;
      end
      ST_ADDR: begin
        hdr_last_s = 5'd23;
`ifdef FLASH_READER_FAST_READ_EN
        hdr_next_s = ST_DUMMY;
`else
        hdr_next_s = ST_DATA;
`endif
      end
      ST_DUMMY: begin
        hdr_last_s = 5'd7;
        hdr_next_s = ST_DATA;
      end
      default: begin
        hdr_last_s = 5'd7;
        hdr_next_s = ST_ADDR;
      end
    endcase
  end

  // Next-state and next-output logic for the whole transaction.
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    tx_s       = tx_r;
    word_cnt_s = word_cnt_r;
    rx_s       = rx_r;
    idle_cnt_s = idle_cnt_r;
    data_s     = data_r;
    busy_s     = busy_r;
    sck_s      = sck_r;
    csn_s      = csn_r;
    mosi_s     = mosi_r;
    if (data_valid_r && data_ready) begin
      data_valid_s = 1'b0;
    end else begin
      data_valid_s = data_valid_r;
    end
    case (state_r)
      ST_IDLE: begin
        csn_s  = 1'b1;
        sck_s  = 1'b0;
        busy_s = 1'b0;
        if (read_start && (read_length != 16'd0)) begin
          state_s    = ST_CMD;
          busy_s     = 1'b1;
          csn_s      = 1'b0;
          mosi_s     = READ_CMD[7];
          tx_s       = {READ_CMD[6:0], read_address, 9'd0};
          bit_cnt_s  = 5'd0;
          word_cnt_s = read_length;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CMD, ST_ADDR, ST_DUMMY: begin
        if (!sck_r) begin
          sck_s = 1'b1;
        end else begin
          sck_s  = 1'b0;
          mosi_s = tx_r[39];
          tx_s   = {tx_r[38:0], 1'b0};
          if (bit_cnt_r == hdr_last_s) begin
            bit_cnt_s = 5'd0;
            state_s   = hdr_next_s;
          end else begin
            bit_cnt_s = bit_cnt_r + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (!sck_r) begin
          // Hold the final bit of a word until the previous word is taken.
          if ((bit_cnt_r == 5'(DATA_WIDTH - 1)) && data_valid_r && !data_ready) begin
            sck_s = 1'b0;
          end else begin
            sck_s = 1'b1;
          end
        end else begin
          sck_s       = 1'b0;
          rx_s[pos_s] = flash_miso;
          if (bit_cnt_r == 5'(DATA_WIDTH - 1)) begin
            bit_cnt_s    = 5'd0;
            data_s       = rx_s;
            data_valid_s = 1'b1;
            if (word_cnt_r == 16'd1) begin
              state_s    = ST_END;
              idle_cnt_s = '0;
            end else begin
              word_cnt_s = word_cnt_r - 16'd1;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + 5'd1;
          end
        end
      end
      ST_END: begin
        csn_s  = 1'b1;
        sck_s  = 1'b0;
        mosi_s = 1'b0;
        if (idle_cnt_r == IW'(CSN_IDLE_CYCLES)) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end else begin
          idle_cnt_s = idle_cnt_r + IW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        csn_s   = 1'b1;
        sck_s   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 5'd0;
      tx_r         <= 40'd0;
      word_cnt_r   <= 16'd0;
      rx_r         <= '0;
      idle_cnt_r   <= '0;
      data_r       <= '0;
      data_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      sck_r        <= 1'b0;
      csn_r        <= 1'b1;
      mosi_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      bit_cnt_r    <= bit_cnt_s;
      tx_r         <= tx_s;
      word_cnt_r   <= word_cnt_s;
      rx_r         <= rx_s;
      idle_cnt_r   <= idle_cnt_s;
      data_r       <= data_s;
      data_valid_r <= data_valid_s;
      busy_r       <= busy_s;
      sck_r        <= sck_s;
      csn_r        <= csn_s;
      mosi_r       <= mosi_s;
    end
  end

  assign busy       = busy_r;
  assign data       = data_r;
  assign data_valid = data_valid_r;
  assign flash_sck  = sck_r;
  assign flash_csn  = csn_r;
  assign flash_mosi = mosi_r;

endmodule

// File: tb/tb_ics32_flash_reader.sv
// Randomized bench for ics32_flash_reader: behavioural SPI flash, scoreboard of expected
// words computed from flash contents, and directed timing/backpressure/reset scenarios.
`timescale 1ns/1ps
module tb_ics32_flash_reader;

  localparam int DW = 16;
  localparam int NB = DW / 8;
`ifdef FLASH_READER_FAST_READ_EN
  localparam int HDR = 40;
  localparam logic [7:0] CMD = 8'h0B;
`else
  localparam int HDR = 32;
  localparam logic [7:0] CMD = 8'h03;
`endif
  localparam int ADDR_LSB = HDR - 32;
  localparam int FIRST_VALID = 2 * HDR + 2 * DW + 1;

  logic          clk = 1'b0;
  logic          reset, read_start, data_ready, flash_miso;
  logic [23:0]   read_address;
  logic [15:0]   read_length;
  logic          busy, data_valid, flash_sck, flash_csn, flash_mosi;
  logic [DW-1:0] data;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          rise_cnt = 0;
  int          csn_falls = 0;
  logic [39:0] hdr_cap = 40'd0;
  logic        prev_sck = 1'b0;
  logic        prev_csn = 1'b1;
  int          stall_cnt = 0;
  bit          stall_arm = 1'b0;
  bit          rand_ready = 1'b0;

  ics32_flash_reader #(.DATA_WIDTH(DW), .CSN_IDLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .read_start(read_start), .read_address(read_address),
    .read_length(read_length), .busy(busy), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .flash_sck(flash_sck), .flash_csn(flash_csn),
    .flash_mosi(flash_mosi), .flash_miso(flash_miso)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (a == 24'h000100) return 8'h34;
    else if (a == 24'h000101) return 8'h12;
    else return a[7:0] ^ a[15:8] ^ {a[20:16], a[23:21]} ^ 8'h5A;
  endfunction

  function automatic logic stream_bit(input logic [23:0] a, input int k);
    logic [7:0] b;
    b = flash_byte(a + 24'(k / 8));
    return b[7 - (k % 8)];
  endfunction

  // Behavioural flash: captures command/address on sck rise, presents data while sck is low.
  always @(negedge clk) begin
    if (flash_csn === 1'b1) begin
      rise_cnt = 0;
    end else begin
      if (prev_csn === 1'b1) begin
        csn_falls++;
        hdr_cap = 40'd0;
      end
      if (flash_sck && !prev_sck) begin
        rise_cnt++;
        if (rise_cnt <= HDR) hdr_cap = {hdr_cap[38:0], flash_mosi};
      end
      if (!flash_sck && rise_cnt >= HDR) flash_miso = stream_bit(hdr_cap[ADDR_LSB +: 24], rise_cnt - HDR);
    end
    prev_sck = flash_sck;
    prev_csn = flash_csn;
  end

  // Consumer: drives data_ready and checks every accepted word against the scoreboard.
  always @(negedge clk) begin
    if (stall_arm && data_valid) begin
      stall_arm = 1'b0;
      stall_cnt = 40;
    end
    if (stall_cnt > 0) begin
      data_ready = 1'b0;
      stall_cnt--;
      if (stall_cnt == 0) begin
        check_value("stall_rises", 64'(rise_cnt), 64'(HDR + 2 * DW - 1));
        check_value("stall_csn", flash_csn, 1'b0);
        check_value("stall_sck", flash_sck, 1'b0);
      end
    end else if (rand_ready) begin
      data_ready = ($urandom_range(0, 3) != 0);
    end else begin
      data_ready = 1'b1;
    end
    if (data_valid && data_ready) begin
      if (exp_q.size() == 0) check_value("unexpected_word", data_valid, 1'b0);
      else check_value("word", 64'(data), exp_q.pop_front());
    end
  end

  task automatic start_read(input logic [23:0] a, input logic [15:0] l);
    logic [63:0] w;
    @(negedge clk);
    if (!busy && l != 16'd0) begin
      for (int i = 0; i < int'(l); i++) begin
        w = 64'd0;
        for (int j = 0; j < NB; j++) w[j*8 +: 8] = flash_byte(a + 24'(i * NB + j));
        exp_q.push_back(w);
      end
    end
    read_address = a;
    read_length  = l;
    read_start   = 1'b1;
    @(negedge clk);
    read_start = 1'b0;
  endtask

  task automatic wait_done(input logic [23:0] a, input int budget);
    int n;
    logic [39:0] exp_hdr;
    n = 0;
    while ((busy || data_valid || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_value("timeout", 64'(n >= budget), 64'd0);
`ifdef FLASH_READER_FAST_READ_EN
    exp_hdr = {CMD, a, 8'h00};
`else
    exp_hdr = {8'h00, CMD, a};
`endif
    check_value("header", 64'(hdr_cap), 64'(exp_hdr));
    check_value("csn_falls", 64'(csn_falls), 64'd1);
  endtask

  initial begin
    logic [23:0] a;
    logic [15:0] l;
    reset = 1'b1; read_start = 1'b0; read_address = 24'd0; read_length = 16'd0;
    data_ready = 1'b1; flash_miso = 1'b0;
    repeat (3) @(negedge clk);
    check_value("rst_busy", busy, 1'b0);
    check_value("rst_valid", data_valid, 1'b0);
    check_value("rst_data", 64'(data), 64'd0);
    check_value("rst_sck", flash_sck, 1'b0);
    check_value("rst_csn", flash_csn, 1'b1);
    check_value("rst_mosi", flash_mosi, 1'b0);
    reset = 1'b0;

    // Directed single-word read with exact cycle timing.
    csn_falls = 0;
    start_read(24'h000100, 16'd1);
    check_value("c1_csn", flash_csn, 1'b0);
    check_value("c1_sck", flash_sck, 1'b0);
    check_value("c1_busy", busy, 1'b1);
    check_value("c1_mosi", flash_mosi, CMD[7]);
    repeat (FIRST_VALID - 2) @(negedge clk);
    check_value("pre_valid", data_valid, 1'b0);
    @(negedge clk);
    check_value("t1_valid", data_valid, 1'b1);
    check_value("t1_data", 64'(data), 64'h1234);
    check_value("t1_csn_low", flash_csn, 1'b0);
    @(negedge clk);
    check_value("t1_csn_high", flash_csn, 1'b1);
    @(negedge clk);
    check_value("t1_busy_end", busy, 1'b1);
    @(negedge clk);
    check_value("t1_busy_low", busy, 1'b0);
    wait_done(24'h000100, 500);

    // Backpressure: 40-cycle stall after word 0.
    csn_falls = 0; stall_arm = 1'b1;
    a = 24'($urandom);
    start_read(a, 16'd4);
    wait_done(a, 3000);

    // Start pulsed mid-transaction is ignored.
    csn_falls = 0;
    a = 24'($urandom);
    start_read(a, 16'd3);
    repeat (30) @(negedge clk);
    read_address = ~a; read_length = 16'd7; read_start = 1'b1;
    @(negedge clk);
    read_start = 1'b0;
    check_value("ign_busy", busy, 1'b1);
    wait_done(a, 3000);

    // Length-0 start is a no-op.
    csn_falls = 0;
    start_read(24'h123456, 16'd0);
    check_value("len0_busy", busy, 1'b0);
    check_value("len0_csn", flash_csn, 1'b1);
    repeat (5) @(negedge clk);
    check_value("len0_falls", 64'(csn_falls), 64'd0);

    // Reset during ADDR, then a clean read.
    csn_falls = 0;
    start_read(24'hABCDEF, 16'd2);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    check_value("abort_csn", flash_csn, 1'b1);
    check_value("abort_sck", flash_sck, 1'b0);
    check_value("abort_busy", busy, 1'b0);
    check_value("abort_valid", data_valid, 1'b0);
    csn_falls = 0;
    start_read(24'h00C0DE, 16'd2);
    wait_done(24'h00C0DE, 2000);

    // Address wrap within one command.
    csn_falls = 0;
    start_read(24'hFFFFFF, 16'd1);
    wait_done(24'hFFFFFF, 2000);

    // Randomized reads with random backpressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      csn_falls = 0;
      a = (t == 0) ? 24'hFFFFFD : 24'($urandom);
      l = 16'($urandom_range(1, 5));
      start_read(a, l);
      wait_done(a, 4000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
